// File: rtl/hazard_unit.sv
// hazard_unit -- ID-stage hazard detection for a 5-stage in-order pipeline.
//
// Tracks the destination registers of the instructions in EX, MEM and WB in a
// 3-entry scoreboard and compares the ID instruction's sources against it.
// A match stalls PC and IF/ID and injects a bubble into ID/EX. A taken
// branch/jump in EX redirects the PC and flushes both IF/ID and ID/EX. If a
// redirect and a data hazard happen in the same cycle, the redirect wins.
//
// Build option:
//   FORWARD_EN defined   -> full forwarding assumed; only a load in EX
//                           followed by a dependent instruction (load-use)
//                           stalls, for exactly one cycle.
//   FORWARD_EN undefined -> no forwarding; any producer in EX/MEM/WB stalls
//                           the consumer until it has left WB (up to 3 cycles).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1/id_rs2, id_re1/2   source registers and their read enables
//   id_rd, id_we, id_is_load  destination, write enable, load flag
//   ex_br_taken               EX resolved a redirect this cycle
//   data_hazard               PC hold
//   control_hazard            PC loads redirect target
//   ifid_stall/ifid_flush     IF/ID hold / clear
//   idex_flush                bubble into ID/EX
//   stall_cnt/flush_cnt       saturating 16-bit stall and redirect counters

// One source-vs-entry comparator; x0 is hardwired zero and never matches.
module hazard_match (
    input  logic       src_re,
    input  logic [4:0] src,
    input  logic       e_valid,
    input  logic       e_we,
    input  logic [4:0] e_rd,
    output logic       hit
);
    assign hit = e_valid && e_we && src_re && (e_rd == src) && (e_rd != 5'd0);
endmodule

module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_re1,
    input  logic        id_re2,
    input  logic [4:0]  id_rd,
    input  logic        id_we,
    input  logic        id_is_load,
    input  logic        ex_br_taken,
    output logic        data_hazard,
    output logic        control_hazard,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } sb_entry_t;

    localparam int NUM_ENTRIES = 3;   // [0]=EX, [1]=MEM, [2]=WB
`ifdef FORWARD_EN
    localparam int NUM_CHK = 1;       // only EX can cause a stall
`else
    localparam int NUM_CHK = 3;
`endif

    sb_entry_t [NUM_ENTRIES-1:0] sb_q, sb_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [15:0]        flush_cnt_q, flush_cnt_d;
    logic [NUM_CHK-1:0] hit1, hit2;
    logic               any_hit;

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_chk
        hazard_match u_m1 (
            .src_re (id_re1),
            .src    (id_rs1),
            .e_valid(sb_q[g].valid),
            .e_we   (sb_q[g].we),
            .e_rd   (sb_q[g].rd),
            .hit    (hit1[g])
        );
        hazard_match u_m2 (
            .src_re (id_re2),
            .src    (id_rs2),
            .e_valid(sb_q[g].valid),
            .e_we   (sb_q[g].we),
            .e_rd   (sb_q[g].rd),
            .hit    (hit2[g])
        );
    end

`ifdef FORWARD_EN
    // ALU results forward from EX/MEM/WB; only load data is too late for EX.
    assign any_hit = (hit1[0] | hit2[0]) & sb_q[0].is_load;
    // WB entry is only tracked, never compared, in this build.
    logic unused_wb;
    assign unused_wb = ^sb_q[2];
`else
    assign any_hit = (|hit1) | (|hit2);
    logic unused_wb;
    assign unused_wb = sb_q[2].is_load;
`endif

    always_comb begin
        // A redirect discards the ID instruction, so it must not also stall.
        data_hazard    = id_valid & any_hit & ~ex_br_taken;
        control_hazard = ex_br_taken;
        ifid_stall     = data_hazard;
        ifid_flush     = control_hazard;
        idex_flush     = data_hazard | control_hazard;

        sb_d[0].valid   = id_valid & ~data_hazard & ~control_hazard;
        sb_d[0].rd      = id_rd;
        sb_d[0].we      = id_we;
        sb_d[0].is_load = id_is_load;
        sb_d[1]         = sb_q[0];
        sb_d[2]         = sb_q[1];

        stall_cnt_d = stall_cnt_q;
        if (data_hazard && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        flush_cnt_d = flush_cnt_q;
        if (control_hazard && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q        <= '0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. A driver applies one stimulus per cycle
// and pushes the expected outputs (from a register-history reference model)
// into a queue; a monitor pops and compares at the falling edge.
module tb_hazard_unit;
    logic        clk = 1'b0;
    logic        rst, id_valid, id_re1, id_re2, id_we, id_is_load, ex_br_taken;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        data_hazard, control_hazard, ifid_stall, ifid_flush, idex_flush;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .data_hazard(data_hazard),
        .control_hazard(control_hazard), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

`ifdef FORWARD_EN
    localparam bit FWD       = 1'b1;
    localparam int STALL_LEN = 1;
`else
    localparam bit FWD       = 1'b0;
    localparam int STALL_LEN = 3;
`endif

    typedef struct packed {
        logic dh, ch, st, ff, xf;
        logic [15:0] sc, fc;
    } exp_t;

    typedef struct {
        logic r, v;
        logic [4:0] rs1, rs2;
        logic re1, re2;
        logic [4:0] rd;
        logic we, ld, br;
    } stim_t;

    typedef struct {
        bit v;
        bit [4:0] rd;
        bit we, ld;
    } ent_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;
    bit   known = 0;
    bit   drv_done = 0;
    ent_t hist[3];          // instructions that entered EX 1, 2, 3 cycles ago
    int   m_sc = 0, m_fc = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{r: 1'b0, v: 1'b0, rs1: 5'd0, rs2: 5'd0, re1: 1'b0, re2: 1'b0,
              rd: 5'd0, we: 1'b0, ld: 1'b0, br: 1'b0};
        return s;
    endfunction

    // Is register r still being produced by an instruction the consumer can't bypass?
    function automatic bit busy(input logic [4:0] r, input logic re);
        if (!re || r == 5'd0) return 1'b0;
        for (int k = 0; k < 3; k++)
            if (hist[k].v && hist[k].we && hist[k].rd == r && (!FWD || (k == 0 && hist[k].ld)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    endtask

    // One cycle: drive, predict, sample hazard, clock, advance model.
    task automatic cyc(input stim_t s, output logic dh);
        exp_t e;
        bit   h;
        rst = s.r; id_valid = s.v; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_re1 = s.re1; id_re2 = s.re2; id_rd = s.rd; id_we = s.we;
        id_is_load = s.ld; ex_br_taken = s.br;
        h = s.v && !s.br && (busy(s.rs1, s.re1) || busy(s.rs2, s.re2));
        e.dh = h; e.ch = s.br; e.st = h; e.ff = s.br; e.xf = h | s.br;
        e.sc = 16'(m_sc); e.fc = 16'(m_fc);
        if (known) q.push_back(e);
        #1 dh = data_hazard;
        @(posedge clk);
        if (s.r) begin
            for (int k = 0; k < 3; k++) hist[k].v = 1'b0;
            m_sc = 0; m_fc = 0; known = 1;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{v: s.v && !h && !s.br, rd: s.rd, we: s.we, ld: s.ld};
            if (h && m_sc < 65535) m_sc++;
            if (s.br && m_fc < 65535) m_fc++;
        end
        #1;
    endtask

    task automatic do_reset();
        stim_t s;
        logic  dh;
        s = idle(); s.r = 1'b1;
        cyc(s, dh);
    endtask

    task automatic monitor();
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {data_hazard, control_hazard, ifid_stall, ifid_flush, idex_flush,
                     stall_cnt, flush_cnt};
                n_chk++;
                if (a === e) n_pass++;
                else $display("FAIL outputs t=%0t got dh%b ch%b st%b ff%b xf%b sc=%0d fc=%0d exp dh%b ch%b st%b ff%b xf%b sc=%0d fc=%0d",
                              $time, a.dh, a.ch, a.st, a.ff, a.xf, a.sc, a.fc,
                              e.dh, e.ch, e.st, e.ff, e.xf, e.sc, e.fc);
            end
            if (drv_done && q.size() == 0) break;
        end
    endtask

    task automatic driver();
        stim_t s, p, c, d;
        logic  dh;
        int    n;
        @(posedge clk); #1;
        do_reset();
        cyc(idle(), dh);                       // reset state
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_flush_cnt", int'(flush_cnt), 0);

        // Producer to x5, dependent consumer held in ID until it issues.
        p = idle(); p.v = 1; p.rd = 5'd5; p.we = 1; p.ld = FWD;
        c = idle(); c.v = 1; c.rd = 5'd6; c.we = 1;
        if (FWD) begin c.rs1 = 5'd5; c.re1 = 1; end
        else     begin c.rs2 = 5'd5; c.re2 = 1; end
        cyc(p, dh);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(c, dh);
            if (dh) n++; else break;
        end
        chk("stall_len", n, STALL_LEN);
        chk("stall_cnt", int'(stall_cnt), STALL_LEN);

        // Writes to x0 never create a dependency.
        do_reset();
        p = idle(); p.v = 1; p.rd = 5'd0; p.we = 1; p.ld = 1;
        c = idle(); c.v = 1; c.rs1 = 5'd0; c.rs2 = 5'd0; c.re1 = 1; c.re2 = 1; c.rd = 5'd3; c.we = 1;
        cyc(p, dh);
        n = 0;
        for (int i = 0; i < 4; i++) begin cyc(c, dh); if (dh) n++; end
        chk("x0_never", n, 0);

        // Load-use coinciding with a redirect: redirect wins, ID load discarded.
        do_reset();
        p = idle(); p.v = 1; p.rd = 5'd7; p.we = 1; p.ld = 1;
        d = idle(); d.v = 1; d.rs1 = 5'd7; d.re1 = 1; d.rd = 5'd9; d.we = 1; d.ld = 1; d.br = 1;
        c = idle(); c.v = 1; c.rs1 = 5'd9; c.re1 = 1; c.rd = 5'd4; c.we = 1;
        cyc(p, dh);
        cyc(d, dh);
        chk("br_wins_dh", int'(dh), 0);
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 0);
        cyc(c, dh);
        chk("discarded_no_hazard", int'(dh), 0);

        // Reset in the middle of a stall releases the consumer.
        do_reset();
        p = idle(); p.v = 1; p.rd = 5'd5; p.we = 1;
        c = idle(); c.v = 1; c.rs2 = 5'd5; c.re2 = 1; c.rd = 5'd8; c.we = 1;
        cyc(p, dh);
        cyc(c, dh);
        c.r = 1; cyc(c, dh);
        c.r = 0; cyc(c, dh);
        chk("rst_release_dh", int'(dh), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);

        // Randomized traffic with small register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            s.r   = ($urandom_range(0, 63) == 0);
            s.v   = 1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1));
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.re1 = 1'($urandom_range(0, 1));
            s.re2 = 1'($urandom_range(0, 1));
            s.rd  = 5'($urandom_range(0, 3));
            s.we  = 1'($urandom_range(0, 1));
            s.ld  = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 7) == 0);
            cyc(s, dh);
        end

        // Counter saturation under back-to-back redirects.
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            s = idle(); s.br = 1;
            s.v = 1'($urandom_range(0, 1)); s.rs1 = 5'($urandom_range(0, 3)); s.re1 = 1;
            s.rd = 5'($urandom_range(0, 3)); s.we = 1; s.ld = 1'($urandom_range(0, 1));
            cyc(s, dh);
        end
        chk("flush_sat", int'(flush_cnt), 65535);

        cyc(idle(), dh);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        drv_done = 1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
        id_rd = 0; id_we = 0; id_is_load = 0; ex_br_taken = 0;
        fork
            driver();
            monitor();
        join_any
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
